// File: rtl/temporizador_bcd_if.sv
// Keypad/control inputs and display/status outputs of the BCD countdown timer.
interface temporizador_bcd_if;
    logic [3:0] D;
    logic       loadn;
    logic       pgt_1Hz;
    logic       start;
    logic       stop;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       magnetron_on;
    logic       done;
    logic       zero;

    modport master (
        output D, loadn, pgt_1Hz, start, stop,
        input  min_ones, sec_tens, sec_ones, magnetron_on, done, zero
    );

    modport slave (
        input  D, loadn, pgt_1Hz, start, stop,
        output min_ones, sec_tens, sec_ones, magnetron_on, done, zero
    );
endinterface

// File: rtl/temporizador_bcd.sv
// Digit-entry register and M:SS BCD countdown timer driving the display and magnetron enable.
module temporizador_bcd (
    input logic               Hz_100_clock,
    input logic               clear,
    temporizador_bcd_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e     r_state, w_state_next;
    logic [3:0] r_min, r_tens, r_ones;
    logic [3:0] w_min_next, w_tens_next, w_ones_next;
    logic [3:0] w_dec_min, w_dec_tens, w_dec_ones;
    logic       r_loadn_q, r_pgt_q;
    logic       w_key, w_tick, w_zero, w_dec_zero, w_digit_ok;

    assign w_key      = r_loadn_q & ~bus.loadn;
    assign w_tick     = ~r_pgt_q & bus.pgt_1Hz;
    assign w_zero     = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_digit_ok = (bus.D <= 4'd9);

    // One-second borrow chain; tens digits above 5 simply count down like any other.
    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_ones = 4'd9;
            w_dec_tens = r_tens - 4'd1;
        end else if (r_min != 4'd0) begin
            w_dec_ones = 4'd9;
            w_dec_tens = 4'd5;
            w_dec_min  = r_min - 4'd1;
        end
    end

    assign w_dec_zero = (w_dec_min == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_ones == 4'd0);

    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_min;
        w_tens_next  = r_tens;
        w_ones_next  = r_ones;
        unique case (r_state)
            StIdle: begin
                if (bus.stop) begin
                    w_min_next  = 4'd0;
                    w_tens_next = 4'd0;
                    w_ones_next = 4'd0;
                end else if (bus.start && !w_zero) begin
                    w_state_next = StRun;
                end else if (w_key && w_digit_ok) begin
                    w_min_next  = r_tens;
                    w_tens_next = r_ones;
                    w_ones_next = bus.D;
                end
            end
            StRun: begin
                if (bus.stop) begin
                    w_state_next = StPause;
                end else if (w_tick) begin
                    w_min_next  = w_dec_min;
                    w_tens_next = w_dec_tens;
                    w_ones_next = w_dec_ones;
                    if (w_dec_zero) begin
                        w_state_next = StDone;
                    end
                end
            end
            StPause: begin
                if (bus.stop) begin
                    w_state_next = StIdle;
                    w_min_next   = 4'd0;
                    w_tens_next  = 4'd0;
                    w_ones_next  = 4'd0;
                end else if (bus.start && !w_zero) begin
                    w_state_next = StRun;
                end
            end
            StDone: begin
                if (bus.stop || bus.start || w_key) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Hz_100_clock) begin
        if (clear) begin
            r_state   <= StIdle;
            r_min     <= 4'd0;
            r_tens    <= 4'd0;
            r_ones    <= 4'd0;
            r_loadn_q <= 1'b1;
            r_pgt_q   <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_min     <= w_min_next;
            r_tens    <= w_tens_next;
            r_ones    <= w_ones_next;
            r_loadn_q <= bus.loadn;
            r_pgt_q   <= bus.pgt_1Hz;
        end
    end

    assign bus.min_ones     = r_min;
    assign bus.sec_tens     = r_tens;
    assign bus.sec_ones     = r_ones;
    assign bus.magnetron_on = (r_state == StRun);
    assign bus.done         = (r_state == StDone);
    assign bus.zero         = w_zero;
endmodule

// File: doc/temporizador_bcd.md
# temporizador_bcd

Digit-entry register and BCD countdown timer for the microwave datapath. Sits directly downstream of the keypad encoder: consumes its BCD digit `D`, key-present strobe `loadn` and 1 Hz tick `pgt_1Hz`. Builds an M:SS time from keypresses, counts it down once per second while cooking, and drives the display digits and the magnetron enable.

## Interface
- No parameters.
- Hz_100_clock  input  1  system clock, 100 Hz; all state updates on its rising edge
- clear  input  1  synchronous, active-high reset
- D  input  4  BCD digit from encoder; valid while loadn = 0
- loadn  input  1  active-low key-present from encoder
- pgt_1Hz  input  1  1 Hz tick from encoder, sampled as data (not used as a clock)
- start  input  1  start/resume request, level sampled each cycle
- stop  input  1  pause/cancel request, level sampled each cycle
- min_ones  output  4  minutes digit, BCD
- sec_tens  output  4  tens-of-seconds digit, BCD
- sec_ones  output  4  seconds digit, BCD
- magnetron_on  output  1  high exactly while in RUN
- done  output  1  high exactly while in DONE
- zero  output  1  combinational: all three digits = 0

## Operation
- Edge detection: registers `loadn_q` and `pgt_q` hold the previous samples.
  - key event = loadn_q & ~loadn
  - tick event = ~pgt_q & pgt_1Hz
- Digit shift on accepted key event, with D ≤ 9: min_ones ← sec_tens, sec_tens ← sec_ones, sec_ones ← D. Old min_ones is discarded.
  - D > 9 is ignored; no shift occurs.
- Decrement on accepted tick event:
  - If sec_ones ≠ 0: sec_ones − 1.
  - Else if sec_tens ≠ 0: sec_ones ← 9, sec_tens − 1.
  - Else if min_ones ≠ 0: sec_ones ← 9, sec_tens ← 5, min_ones − 1.
  - Entered tens values 6–9 are legal; they count down normally.
- FSM states: IDLE, RUN, PAUSE, DONE. Stop has priority over start in the same cycle.
- IDLE:
  - stop clears all digits.
  - start with zero = 0 moves to RUN, and the key event in that cycle is ignored.
  - start with zero = 1 is ignored.
  - Otherwise a key event shifts.
- RUN:
  - stop moves to PAUSE.
  - Otherwise a tick event decrements.
  - If a decrement yields 0:00, next state is DONE.
  - Key events are ignored.
- PAUSE:
  - stop moves to IDLE and clears digits.
  - start with zero = 0 moves to RUN.
  - Ticks and keys are ignored; digits are held.
- DONE:
  - Digits stay 0:00.
  - stop, start or a key event moves to IDLE; that key event does not shift.
- Reset value (clear = 1):
  - State is IDLE; all digits are 0.
  - loadn_q = 1 and pgt_q = 1, so an input held after reset produces no spurious event.
  - magnetron_on = 0, done = 0, zero = 1.
- Reset mid-RUN aborts immediately; there is no pending decrement or shift afterwards.

## Timing
- The event and its effect land on the same clock edge at which the event condition is sampled true: digit shift, decrement, state change. Outputs are updated one edge after the input transition.
- magnetron_on and done are registered from state, with no combinational path from inputs.
- zero is combinational from the digit registers.
- Exactly one shift per loadn high→low transition, however long loadn is held low.
- Exactly one decrement per pgt_1Hz low→high transition.
- RUN→DONE happens on the same edge as the final decrement to 0:00.
  - magnetron_on falls and done rises together.
  - No extra tick is consumed.
- start held high across DONE→IDLE does not re-enter RUN, because zero = 1.

## Test plan
- Reset then key entry:
  - Stimulus: clear pulse, then key presses 1, 3, 0 (D = 1, 3, 0, each as a loadn low pulse).
  - Required: digits 1:30 and zero = 0; a loadn held low for 50 cycles shifts once.
- Countdown with borrow:
  - Stimulus: load 1:00, start, 1 tick.
  - Required: 0:59 and magnetron_on = 1.
  - Then 59 further ticks: 0:00, done = 1 and magnetron_on = 0 on the same edge.
- Pause/resume/cancel:
  - Stimulus: load 0:10, start, 3 ticks.
  - Required: 0:07.
  - Stop, then 5 ticks: still 0:07, state PAUSE.
  - Start, 1 tick: 0:06.
  - Stop twice: IDLE with 0:00.
- Priority and guards:
  - Start with 0:00: remains IDLE.
  - Start and stop in the same cycle in IDLE with 0:05: digits cleared, no RUN.
  - Key event in the same cycle as an accepted start: no shift.
  - D = 12 key event: ignored.
- Out-of-range tens:
  - Stimulus: load 0:99, start, 10 ticks.
  - Required: 0:89; countdown continues to 0:00 and reaches DONE after 99 ticks total.
- Reset mid-run:
  - Stimulus: clear during RUN at 0:42 with pgt_1Hz high.
  - Required: 0:00, IDLE, magnetron_on = 0; no decrement on the first cycle after clear is released.
